pipelined_and_chain: RTL and testbench

PIPELINED_AND_CHAIN -- requirements
Module: pipelined_and_chain

---
 rtl/pipelined_and_chain_if.sv | 26 ++
 rtl/pipelined_and_chain.sv | 121 ++++++++++++
 tb/tb_pipelined_and_chain.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_and_chain_if.sv
// Handshake bundle for pipelined_and_chain: input stream, result stream and the
// optional ones counter. The slave modport is the DUT side.
interface pipelined_and_chain_if #(
  parameter int N_IN = 8
) ();
  localparam int ZW = $clog2(N_IN + 1);

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_and;
  logic [ZW-1:0]   out_zidx;
  logic [15:0]     out_ones_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_and, out_zidx, out_ones_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_and, out_zidx, out_ones_cnt
  );
endinterface

// File: rtl/pipelined_and_chain.sv
// D-stage AND-reduction pipeline that also reports the index of the lowest 0 bit.
// Define AND_CHAIN_STATS_EN to enable the saturating count of out_and=1 results.
module pipelined_and_chain #(
  parameter int N_IN  = 8,
  parameter int GROUP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_and_chain_if.slave  bus
);
  localparam int D  = (N_IN + GROUP - 1) / GROUP;
  localparam int ZW = $clog2(N_IN + 1);

  // The whole operand rides along so each stage folds bits of its own transaction.
  typedef struct packed {
    logic            prod;
    logic [ZW-1:0]   zidx;
    logic [N_IN-1:0] data;
  } stage_t;

  stage_t         stage_q [D];
  stage_t         stage_d [D];
  stage_t         init_s;
  logic [D-1:0]   valid_q;
  logic [D-1:0]   valid_d;
  logic [D-1:0]   en;
  logic           en_acc;
  logic           in_ready;
  logic           in_fire;
  logic           out_fire;

  function automatic stage_t fold(input int k, input stage_t s);
    stage_t r;
    r = s;
    for (int i = 0; i < N_IN; i++) begin
      if (i >= k * GROUP && i < (k + 1) * GROUP && r.prod && !r.data[i]) begin
        r.prod = 1'b0;
        r.zidx = ZW'(i);
      end
    end
    return r;
  endfunction

  // en[k]: stage k may load this cycle (it is empty, or every stage downstream
  // of it can shift). Built as a running OR so no bit of en feeds another.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    en     = '0;
    en_acc = bus.out_ready;
    for (int k = D - 1; k >= 0; k--) begin
      en_acc = en_acc | ~valid_q[k];
      en[k]  = en_acc;
    end
  end

  assign in_ready = !rst && en[0];
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = valid_q[D-1] && bus.out_ready;

  always_comb begin
    init_s      = '0;
    init_s.prod = 1'b1;
    init_s.zidx = ZW'(N_IN);
    init_s.data = bus.in_data;

    stage_d = stage_q;
    valid_d = valid_q;

    if (en[0]) begin
      stage_d[0] = fold(0, init_s);
      valid_d[0] = in_fire;
    end
    for (int k = 1; k < D; k++) begin
      if (en[k]) begin
        stage_d[k] = fold(k, stage_q[k-1]);
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the payload registers are reset too, so out_and/out_zidx read 0 under reset.
      for (int k = 0; k < D; k++) stage_q[k] <= '0;
    end else begin
      // NOTE: non-blocking updates so every stage samples its predecessor's old value.
      valid_q <= valid_d;
      for (int k = 0; k < D; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q[D-1];
  assign bus.out_and   = stage_q[D-1].prod;
  assign bus.out_zidx  = stage_q[D-1].zidx;

`ifdef AND_CHAIN_STATS_EN
  logic [15:0] ones_cnt_q;
  logic [15:0] ones_cnt_d;

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (out_fire && stage_q[D-1].prod && ones_cnt_q != 16'hFFFF) begin
      ones_cnt_d = ones_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ones_cnt_q <= '0;
    else     ones_cnt_q <= ones_cnt_d;
  end

  assign bus.out_ones_cnt = ones_cnt_q;
`else
  logic unused_out_fire;
  assign unused_out_fire  = out_fire;
  assign bus.out_ones_cnt = '0;
`endif

endmodule

// File: tb/tb_pipelined_and_chain.sv
// Self-checking bench: directed tables and sequences plus random traffic against
// a queue-based reference of the AND / lowest-zero / ones-count behaviour.
module tb_pipelined_and_chain;
  localparam int N_IN  = 8;
  localparam int GROUP = 2;
  localparam int D     = 4;
  localparam int N2    = 5;
  localparam int G2    = 3;
`ifdef AND_CHAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipelined_and_chain_if #(.N_IN(N_IN)) bus ();
  pipelined_and_chain_if #(.N_IN(N2))   bus2 ();

  pipelined_and_chain #(.N_IN(N_IN), .GROUP(GROUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipelined_and_chain #(.N_IN(N2), .GROUP(G2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct {
    logic [7:0] data;
    int         acc;
  } txn_t;

  typedef struct {
    logic [7:0] data;
    logic       exp_and;
    int         exp_zidx;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ones_exp = 0;
  txn_t q[$];

  logic       s_ov;
  logic       s_oa;
  logic [3:0] s_oz;
  logic       s_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_and(input logic [7:0] d);
    return d == 8'hFF;
  endfunction

  function automatic int ref_zidx(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (d[i] == 1'b0) return i;
    return 8;
  endfunction

  // One clock cycle on the main DUT: drive, check at negedge, then update the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy);
    logic exp_ov;
    logic fire_in;
    logic fire_out;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    s_ov = bus.out_valid;
    s_oa = bus.out_and;
    s_oz = bus.out_zidx;
    s_ir = bus.in_ready;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + D - 1);
    check("out_valid", 32'(s_ov), 32'(exp_ov));
    if (exp_ov) begin
      check("out_and", 32'(s_oa), 32'(ref_and(q[0].data)));
      check("out_zidx", 32'(s_oz), 32'(ref_zidx(q[0].data)));
    end
    check("in_ready", 32'(s_ir), 32'((q.size() < D) || ordy));
    check("ones_cnt", 32'(bus.out_ones_cnt), 32'(ones_exp));
    fire_in  = v && s_ir;
    fire_out = s_ov && ordy;
    @(posedge clk);
    #1;
    cyc++;
    if (fire_out && q.size() > 0) begin
      if (STATS && ref_and(q[0].data) && ones_exp < 65535) ones_exp++;
      void'(q.pop_front());
    end
    if (fire_in) q.push_back('{data: d, acc: cyc});
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_and", 32'(bus.out_and), 32'd0);
    check("rst_out_zidx", 32'(bus.out_zidx), 32'd0);
    check("rst_ones_cnt", 32'(bus.out_ones_cnt), 32'd0);
    check("rst_out_valid2", 32'(bus2.out_valid), 32'd0);
    q.delete();
    ones_exp = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
  endtask

  vec_t       tbl [8];
  logic [7:0] stall_data [6];

  initial begin
    int first_ov;
    int sent;
    int delivered;
    int stale;
    int n;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    tbl[0] = '{8'hFF, 1'b1, 8};
    tbl[1] = '{8'hFE, 1'b0, 0};
    tbl[2] = '{8'h7F, 1'b0, 7};
    tbl[3] = '{8'hEF, 1'b0, 4};
    tbl[4] = '{8'h00, 1'b0, 0};
    tbl[5] = '{8'hFD, 1'b0, 1};
    tbl[6] = '{8'hBF, 1'b0, 6};
    tbl[7] = '{8'hFF, 1'b1, 8};

    stall_data[0] = 8'h3C; stall_data[1] = 8'hFF; stall_data[2] = 8'hF7;
    stall_data[3] = 8'h01; stall_data[4] = 8'hFF; stall_data[5] = 8'h9F;

    #1;
    do_reset();

    // Single 0xFF: result four cycles after the input cycle.
    first_ov = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0, 8'hFF, 1'b1);
      if (s_ov && first_ov < 0) begin
        first_ov = i;
        check("single_and", 32'(s_oa), 32'd1);
        check("single_zidx", 32'(s_oz), 32'd8);
      end
    end
    check("single_latency", 32'(first_ov), 32'd4);

    // Back-to-back table: results on consecutive cycles.
    for (int i = 0; i < 8 + D; i++) begin
      cycle(i < 8, (i < 8) ? tbl[i].data : 8'h00, 1'b1);
      if (i >= D) begin
        check("tbl_valid", 32'(s_ov), 32'd1);
        check("tbl_and", 32'(s_oa), 32'(tbl[i-D].exp_and));
        check("tbl_zidx", 32'(s_oz), 32'(tbl[i-D].exp_zidx));
      end else begin
        check("tbl_idle", 32'(s_ov), 32'd0);
      end
    end
    drain(10);

    // Backpressure: only D accepted while stalled, then all six delivered in order.
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(sent < 6, stall_data[sent % 6], 1'b0);
      if (sent < 6 && s_ir) sent++;
    end
    check("stall_accepted", 32'(sent), 32'd4);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    delivered = 0;
    n = 0;
    while ((sent < 6 || q.size() > 0) && n < 30) begin
      cycle(sent < 6, stall_data[sent % 6], 1'b1);
      if (sent < 6 && s_ir) sent++;
      if (s_ov) delivered++;
      n++;
    end
    check("stall_delivered", 32'(delivered), 32'd6);

    // Reset with three transactions in flight, one of them at the output.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("pre_rst_valid", 32'(s_ov), 32'd1);
    do_reset();
    stale = 0;
    for (int i = 0; i < D + 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (s_ov) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cycle(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0));
    end
    drain(50);

    // Odd geometry: N_IN=5, GROUP=3, two stages.
    bus.in_valid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = (t == 0) ? 5'h0F : 5'h1F;
      @(negedge clk);
      check("g2_in_ready", 32'(bus2.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      check("g2_early", 32'(bus2.out_valid), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("g2_valid", 32'(bus2.out_valid), 32'd1);
      check("g2_and", 32'(bus2.out_and), (t == 0) ? 32'd0 : 32'd1);
      check("g2_zidx", 32'(bus2.out_zidx), (t == 0) ? 32'd4 : 32'd5);
      @(posedge clk);
      #1;
    end

    // Ones counter: saturates with stats, stays 0 without.
    for (int i = 0; i < 70000; i++) cycle(1'b1, 8'hFF, 1'b1);
    drain(10);
    check("ones_sat", 32'(bus.out_ones_cnt), STATS ? 32'hFFFF : 32'd0);

    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
